// File: rtl/mii_rx_deser.sv
// Receive deserialiser: packs LSB-first line beats into OUT_W-bit words,
// optionally strips preamble/SFD, and reports frame boundaries, status and length.
module mii_rx_deser #(
    parameter int IN_W           = 4,
    parameter int OUT_W          = 8,
    parameter int STRIP_PREAMBLE = 1,
    parameter int MAX_LEN        = 1518
) (
    input  logic                        mii_clk,
    input  logic                        reset,
    input  logic                        mii_en,
    input  logic                        mii_er,
    input  logic [IN_W-1:0]             mii_d,
    output logic                        rdy,
    output logic [OUT_W-1:0]            q,
    output logic [$clog2(OUT_W/8):0]    q_bytes,
    output logic                        sof,
    output logic                        eof,
    output logic                        err,
    output logic [15:0]                 len
);

    localparam int              BC_W     = $clog2(OUT_W) + 1;
    localparam int              QB_W     = $clog2(OUT_W/8) + 1;
    localparam logic [7:0]      PRE8     = 8'h55;
    localparam logic [7:0]      SFD_SH   = 8'hD5 >> (8 - IN_W);
    localparam logic [IN_W-1:0] PRE_BEAT = PRE8[IN_W-1:0];
    localparam logic [IN_W-1:0] SFD_BEAT = SFD_SH[IN_W-1:0];
    localparam logic [15:0]     LEN_CAP  = 16'(MAX_LEN + 1);

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

    state_t             state;
    logic [OUT_W-1:0]   acc;
    logic [BC_W-1:0]    bitcnt;
    logic               seen55;
    logic               fresh;
    logic               word_sent;
    logic               ovs;
    logic               post_rst;

    logic               take;
    logic               first_beat;
    logic [OUT_W-1:0]   acc_ins;
    logic [BC_W-1:0]    bit_sum;
    logic               byte_done;
    logic               word_done;
    logic               oversize;
    logic [15:0]        len_base;
    logic [16:0]        len_inc;
    logic               err_base;
    logic [QB_W-1:0]    tail_bytes;
    logic               dribble;

    function automatic logic [15:0] sat_len(input logic [16:0] x);
        if (x > {1'b0, LEN_CAP})
            return LEN_CAP;
        return x[15:0];
    endfunction

    function automatic logic [OUT_W-1:0] byte_mask(input logic [QB_W-1:0] nb);
        logic [OUT_W-1:0] m;
        m = '0;
        for (int i = 0; i < OUT_W/8; i++)
            if (i < int'(nb))
                m[8*i +: 8] = 8'hFF;
        return m;
    endfunction

    // Beat insertion and byte/word bookkeeping for the current line beat
    always_comb begin
        take       = mii_en && !post_rst &&
                     ((state == DATA) || (state == IDLE && STRIP_PREAMBLE == 0));
        first_beat = (state == IDLE) || fresh;
        acc_ins    = acc | (OUT_W'(mii_d) << bitcnt);
        bit_sum    = bitcnt + BC_W'(IN_W);
        byte_done  = (bit_sum[2:0] == 3'd0);
        word_done  = (bit_sum == BC_W'(OUT_W));
        len_base   = first_beat ? 16'd0 : len;
        len_inc    = {1'b0, len_base} + 17'(byte_done);
        oversize   = byte_done && (len_base >= 16'(MAX_LEN));
        err_base   = first_beat ? 1'b0 : err;
        tail_bytes = QB_W'(bitcnt >> 3);
        dribble    = (bitcnt[2:0] != 3'd0);
    end

    always_ff @(posedge mii_clk) begin
        if (reset) begin
            state     <= IDLE;
            acc       <= '0;
            bitcnt    <= '0;
            seen55    <= 1'b0;
            fresh     <= 1'b0;
            word_sent <= 1'b0;
            ovs       <= 1'b0;
            post_rst  <= 1'b1;
            rdy       <= 1'b0;
            q         <= '0;
            q_bytes   <= '0;
            sof       <= 1'b0;
            eof       <= 1'b0;
            err       <= 1'b0;
            len       <= '0;
        end else begin
            rdy      <= 1'b0;
            sof      <= 1'b0;
            eof      <= 1'b0;
            post_rst <= 1'b0;
            if (take) begin
                len   <= sat_len(len_inc);
                err   <= err_base | mii_er | oversize;
                fresh <= 1'b0;
                if (oversize) begin
                    state     <= DROP;
                    ovs       <= 1'b1;
                    acc       <= '0;
                    bitcnt    <= '0;
                    word_sent <= 1'b0;
                end else begin
                    state <= DATA;
                    if (word_done) begin
                        rdy       <= 1'b1;
                        q         <= acc_ins;
                        q_bytes   <= QB_W'(OUT_W/8);
                        sof       <= !word_sent;
                        word_sent <= 1'b1;
                        acc       <= '0;
                        bitcnt    <= '0;
                    end else begin
                        acc    <= acc_ins;
                        bitcnt <= bit_sum;
                    end
                end
            end else begin
                case (state)
                    IDLE: begin
                        seen55 <= (mii_d == PRE_BEAT);
                        if (mii_en)
                            state <= post_rst ? DROP : PREAMBLE;
                    end
                    PREAMBLE: begin
                        if (!mii_en) begin
                            state <= IDLE;
                        end else if (mii_d == SFD_BEAT && seen55) begin
                            state     <= DATA;
                            fresh     <= 1'b1;
                            word_sent <= 1'b0;
                        end else if (mii_d == PRE_BEAT) begin
                            seen55 <= 1'b1;
                        end else begin
                            state <= DROP;
                        end
                    end
                    DATA: begin
                        // mii_en low here: close the frame, flushing whole pending bytes
                        state     <= IDLE;
                        eof       <= 1'b1;
                        acc       <= '0;
                        bitcnt    <= '0;
                        word_sent <= 1'b0;
                        fresh     <= 1'b0;
                        if (fresh) begin
                            err <= 1'b0;
                            len <= '0;
                        end else begin
                            err <= err | dribble;
                            if (tail_bytes != '0) begin
                                rdy     <= 1'b1;
                                q       <= acc & byte_mask(tail_bytes);
                                q_bytes <= tail_bytes;
                                sof     <= !word_sent;
                            end
                        end
                    end
                    DROP: begin
                        if (!mii_en) begin
                            state <= IDLE;
                            eof   <= ovs;
                            ovs   <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

endmodule
